mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the decoded control word: accepts an execute-stage bundle, performs the load/store on the data bus, and produces the memory-stage bundle.
- Drives the dbus request from a registered copy of the instruction and holds it until the response arrives.
- Extracts the loaded data and sign- or zero-extends it according to memsize and zeroextwb.
- Stalls the upstream pipeline while an access is outstanding. Sits between the execute and writeback pipeline registers.

Parameters:
- TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog. Reaching the limit aborts the access with err=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in  in  execute_data_t  execute-stage bundle; must be held stable while stall=1
- out  out  memory_data_t  registered memory-stage bundle
- stall  out  1  freeze execute and earlier stages
- dreq  out  dbus_req_t  fields: valid, addr, size, strobe, data
- dresp  in  dbus_resp_t  only data_ok and data are used
- err  out  1  one-cycle pulse: misaligned access or watchdog abort

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: out all-zero (out.valid=0); stall=0; dreq all-zero; err=0; state=IDLE; watchdog counter=0.
- Memory operation: in.valid && (ctl.memread || ctl.memwrite). memread and memwrite never both set.
- States:
  - IDLE
    - No valid input: out.valid=0 next cycle.
    - Non-memory op: out = {in fields, aluout, readdata=0, writedata=aluout} next cycle (1-cycle latency); stall=0.
    - Aligned memory op: latch in into pend; go to REQ; stall=1 this cycle.
    - Misaligned memory op: no bus request; out.valid=1 next cycle with readdata=0; err=1 next cycle; stall=0.
  - REQ
    - dreq.valid=1, driven from pend; stall=1.
    - dresp.data_ok=1: capture result into out (visible next cycle); stall=0 this cycle so upstream advances; go to IDLE.
    - Next-cycle IDLE evaluates the new in normally. There is no bubble beyond the REQ cycles.
- Alignment by memsize: MSIZE1 always aligned; MSIZE2 needs addr[0]=0; MSIZE4 needs addr[1:0]=0; MSIZE8 needs addr[2:0]=0. addr = aluout.
- dreq fields:
  - addr = pend.aluout; size = pend.ctl.memsize.
  - Store strobe: (MSIZE1: 8'h01, MSIZE2: 8'h03, MSIZE4: 8'h0F, MSIZE8: 8'hFF) << addr[2:0].
  - Store data = memwd << (8*addr[2:0]).
  - Loads: strobe=0, data=0.
  - All dreq fields are constant while in REQ.
- Load result:
  - sh = dresp.data >> (8*addr[2:0]); take the low 8/16/32/64 bits per memsize.
  - Sign-extend unless ctl.zeroextwb=1, then zero-extend.
  - out.readdata = extended value; out.writedata = readdata.
- Store result: out.readdata=0; out.writedata=aluout.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts REQ cycles; reset to 0 on entering REQ.
  - On reaching TIMEOUT_CYCLES with no data_ok: go to IDLE, out.valid=1 with readdata=0, err=1, dreq.valid=0.
- Simultaneous events: data_ok in the same cycle the watchdog expires is treated as success, no err.
- data_ok while in IDLE is ignored.
- Reset in REQ: dreq.valid drops the following cycle; the access is abandoned; no output is produced.
- Pass-through: pc, raw_instr, ctl, ra1, ra2, dst, aluout copied unchanged into out.

Test Plan:
- ADD-type, in.valid=1, aluout=64'h5 -> next cycle out.valid=1, writedata=5, stall=0, dreq.valid=0.
- LB, addr=0x1003, dresp.data=64'h00000000_80000000 with data_ok 3 cycles after REQ entry -> stall high 4 cycles; out.readdata=64'hFFFF_FFFF_FFFF_FF80; LBU (zeroextwb=1) with the same data gives 64'h80.
- SH, addr=0x2002, memwd=64'hABCD -> dreq.strobe=8'h0C, dreq.data=64'hABCD_0000, size=MSIZE2; held until data_ok.
- LW, addr=0x3002 -> no dreq.valid; err pulse; out.valid=1, readdata=0 next cycle.
- TIMEOUT_CYCLES=4, LD with no data_ok -> err after 4 REQ cycles, stall released; repeat with data_ok at exactly cycle 4 -> success, err=0.
- Back-to-back LD then SD, each data_ok after 1 cycle -> two results in order, dreq.valid deasserts between them; reset asserted mid-REQ -> all outputs zero next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues data-bus loads/stores and builds the memory-stage bundle.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   zeroextwb;
    msize_t memsize;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dst;
    logic [63:0] aluout;
    logic [63:0] memwd;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dst;
    logic [63:0] aluout;
    logic [63:0] readdata;
    logic [63:0] writedata;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t in,
  output memory_data_t  out,
  output logic          stall,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t              state, state_n;
  execute_data_t       pend, pend_n;
  memory_data_t        out_n;
  logic                err_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [63:0]         shifted;
  logic [63:0]         load_val;
  logic                unused_addr_ok;

  // Only data_ok and data matter; the address handshake is not tracked.
  assign unused_addr_ok = dresp.addr_ok;

  // Natural alignment check for the requested access size.
  function automatic logic is_aligned(input msize_t sz, input logic [2:0] a);
    case (sz)
      MSIZE1:  return 1'b1;
      MSIZE2:  return a[0] == 1'b0;
      MSIZE4:  return a[1:0] == 2'b00;
      default: return a == 3'b000;
    endcase
  endfunction

  // Byte-lane mask for a store of the given size at the given byte offset.
  function automatic logic [7:0] lane_mask(input msize_t sz, input logic [2:0] a);
    logic [7:0] base;
    case (sz)
      MSIZE1:  base = 8'h01;
      MSIZE2:  base = 8'h03;
      MSIZE4:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << a;
  endfunction

  // Sign- or zero-extend the low bytes of a lane-shifted load.
  function automatic logic [63:0] extend(input msize_t sz, input logic zx, input logic [63:0] sh);
    case (sz)
      MSIZE1:  return zx ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MSIZE2:  return zx ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MSIZE4:  return zx ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Copy the pass-through fields of an execute bundle into a memory bundle.
  function automatic memory_data_t pass(input execute_data_t e, input logic [63:0] rd,
                                        input logic [63:0] wd);
    memory_data_t o;
    o.valid     = e.valid;
    o.pc        = e.pc;
    o.raw_instr = e.raw_instr;
    o.ctl       = e.ctl;
    o.ra1       = e.ra1;
    o.ra2       = e.ra2;
    o.dst       = e.dst;
    o.aluout    = e.aluout;
    o.readdata  = rd;
    o.writedata = wd;
    return o;
  endfunction

  // Load data path from the pending access.
  always_comb begin
    shifted  = dresp.data >> {pend.aluout[2:0], 3'b000};
    load_val = extend(pend.ctl.memsize, pend.ctl.zeroextwb, shifted);
  end

  // Next-state, bus request, stall and next output bundle.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    out_n   = '0;
    err_n   = 1'b0;
    cnt_n   = cnt;
    stall   = 1'b0;
    dreq    = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (in.valid) begin
          if (in.ctl.memread || in.ctl.memwrite) begin
            if (is_aligned(in.ctl.memsize, in.aluout[2:0])) begin
              pend_n  = in;
              state_n = REQ;
              stall   = 1'b1;
            end else begin
              out_n = pass(in, 64'd0, in.aluout);
              err_n = 1'b1;
            end
          end else begin
            out_n = pass(in, 64'd0, in.aluout);
          end
        end
      end
      REQ: begin
        dreq.valid = 1'b1;
        dreq.addr  = pend.aluout;
        dreq.size  = pend.ctl.memsize;
        if (pend.ctl.memwrite) begin
          dreq.strobe = lane_mask(pend.ctl.memsize, pend.aluout[2:0]);
          dreq.data   = pend.memwd << {pend.aluout[2:0], 3'b000};
        end
        stall = 1'b1;
        if (dresp.data_ok) begin
          stall   = 1'b0;
          state_n = IDLE;
          out_n   = pend.ctl.memread ? pass(pend, load_val, load_val)
                                     : pass(pend, 64'd0, pend.aluout);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(LIMIT))) begin
          stall   = 1'b0;
          state_n = IDLE;
          out_n   = pass(pend, 64'd0, pend.aluout);
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Pending access, output bundle, error pulse and watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      out  <= '0;
      err  <= 1'b0;
      cnt  <= '0;
    end else begin
      pend <= pend_n;
      out  <= out_n;
      err  <= err_n;
      cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one default instance, one with a 4-cycle watchdog.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic          clk;
  logic          reset;
  execute_data_t in_a, in_b;
  memory_data_t  out_a, out_b;
  logic          stall_a, stall_b;
  dbus_req_t     dreq_a, dreq_b;
  dbus_resp_t    dresp_a, dresp_b;
  logic          err_a, err_b;

  int            n_chk;
  int            n_pass;
  int            stalls;
  dbus_req_t     rq0, rq1;

  mem_access_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_a),
    .out   (out_a),
    .stall (stall_a),
    .dreq  (dreq_a),
    .dresp (dresp_a),
    .err   (err_a)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) u_wd (
    .clk   (clk),
    .reset (reset),
    .in    (in_b),
    .out   (out_b),
    .stall (stall_b),
    .dreq  (dreq_b),
    .dresp (dresp_b),
    .err   (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic execute_data_t mk(input logic [63:0] pc, input logic rd, input logic wr,
                                       input msize_t sz, input logic zx,
                                       input logic [63:0] alu, input logic [63:0] wd);
    execute_data_t e;
    e               = '0;
    e.valid         = 1'b1;
    e.pc            = pc;
    e.raw_instr     = 32'(pc) ^ 32'h0000_1013;
    e.ctl.regwrite  = rd || !wr;
    e.ctl.memread   = rd;
    e.ctl.memwrite  = wr;
    e.ctl.zeroextwb = zx;
    e.ctl.memsize   = sz;
    e.ra1           = 5'd1;
    e.ra2           = 5'd2;
    e.dst           = 5'd3;
    e.aluout        = alu;
    e.memwd         = wd;
    return e;
  endfunction

  // Run one aligned access on instance A: data_ok after 'waits' REQ cycles.
  task automatic access(input execute_data_t e, input int waits, input logic [63:0] rdata,
                        output int st, output dbus_req_t first_req, output dbus_req_t last_req);
    st   = 0;
    in_a = e;
    #1;
    if (stall_a) st++;
    tick();
    first_req = dreq_a;
    for (int i = 0; i < waits; i++) begin
      if (stall_a) st++;
      tick();
    end
    dresp_a.data_ok = 1'b1;
    dresp_a.data    = rdata;
    #1;
    if (stall_a) st++;
    last_req = dreq_a;
    tick();
    dresp_a = '0;
    in_a    = '0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    in_a    = '0;
    in_b    = '0;
    dresp_a = '0;
    dresp_b = '0;
    reset   = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 64'(out_a.valid), 64'd0);
    check("rst_out_alu",   out_a.aluout,      64'd0);
    check("rst_stall",     64'(stall_a),      64'd0);
    check("rst_dreq",      64'(dreq_a.valid), 64'd0);
    check("rst_err",       64'(err_a),        64'd0);
    check("rst_wd_valid",  64'(out_b.valid),  64'd0);
    reset = 1'b0;
    tick();

    // Non-memory op: one-cycle pass-through
    in_a = mk(64'h100, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h5, 64'h0);
    #1;
    check("add_stall", 64'(stall_a), 64'd0);
    tick();
    in_a = '0;
    #1;
    check("add_valid", 64'(out_a.valid),  64'd1);
    check("add_wd",    out_a.writedata,   64'h5);
    check("add_rd",    out_a.readdata,    64'h0);
    check("add_pc",    out_a.pc,          64'h100);
    check("add_dst",   64'(out_a.dst),    64'd3);
    check("add_dreq",  64'(dreq_a.valid), 64'd0);
    tick();
    check("add_bubble", 64'(out_a.valid), 64'd0);

    // LB, signed, data_ok three cycles after REQ entry
    access(mk(64'h104, 1'b1, 1'b0, MSIZE1, 1'b0, 64'h1003, 64'h0), 3,
           64'h0000_0000_8000_0000, stalls, rq0, rq1);
    check("lb_stalls",   64'(stalls),     64'd4);
    check("lb_req_v",    64'(rq0.valid),  64'd1);
    check("lb_req_addr", rq0.addr,        64'h1003);
    check("lb_req_strb", 64'(rq0.strobe), 64'h0);
    check("lb_req_size", 64'(rq0.size),   64'(MSIZE1));
    check("lb_valid",    64'(out_a.valid), 64'd1);
    check("lb_rd",       out_a.readdata,  64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wd",       out_a.writedata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_err",      64'(err_a),      64'd0);

    // LBU, same data, zero-extended
    access(mk(64'h108, 1'b1, 1'b0, MSIZE1, 1'b1, 64'h1003, 64'h0), 0,
           64'h0000_0000_8000_0000, stalls, rq0, rq1);
    check("lbu_stalls", 64'(stalls),  64'd1);
    check("lbu_rd",     out_a.readdata, 64'h80);

    // SH at offset 2: lanes 2-3, request held until data_ok
    access(mk(64'h10C, 1'b0, 1'b1, MSIZE2, 1'b0, 64'h2002, 64'hABCD), 2,
           64'hFFFF_FFFF_FFFF_FFFF, stalls, rq0, rq1);
    check("sh_stalls",    64'(stalls),     64'd3);
    check("sh_req_addr",  rq0.addr,        64'h2002);
    check("sh_req_strb",  64'(rq0.strobe), 64'h0C);
    check("sh_req_data",  rq0.data,        64'hABCD_0000);
    check("sh_req_size",  64'(rq0.size),   64'(MSIZE2));
    check("sh_hold_v",    64'(rq1.valid),  64'd1);
    check("sh_hold_strb", 64'(rq1.strobe), 64'h0C);
    check("sh_hold_data", rq1.data,        64'hABCD_0000);
    check("sh_rd",        out_a.readdata,  64'h0);
    check("sh_wd",        out_a.writedata, 64'h2002);

    // LW misaligned: no request, error pulse, immediate result
    in_a = mk(64'h110, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h3002, 64'h0);
    #1;
    check("lw_stall", 64'(stall_a),      64'd0);
    check("lw_dreq",  64'(dreq_a.valid), 64'd0);
    tick();
    in_a = '0;
    #1;
    check("lw_valid",     64'(out_a.valid),  64'd1);
    check("lw_rd",        out_a.readdata,    64'h0);
    check("lw_err",       64'(err_a),        64'd1);
    check("lw_dreq_next", 64'(dreq_a.valid), 64'd0);
    tick();
    check("lw_err_pulse", 64'(err_a), 64'd0);

    // Back-to-back LD then SD
    access(mk(64'h114, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h4000, 64'h0), 1,
           64'h1122_3344_5566_7788, stalls, rq0, rq1);
    check("ld_pc",    out_a.pc,          64'h114);
    check("ld_rd",    out_a.readdata,    64'h1122_3344_5566_7788);
    check("ld_gap",   64'(dreq_a.valid), 64'd0);
    access(mk(64'h118, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h4008, 64'hDEAD), 1,
           64'h0, stalls, rq0, rq1);
    check("sd_strb",  64'(rq0.strobe),   64'hFF);
    check("sd_data",  rq0.data,          64'hDEAD);
    check("sd_pc",    out_a.pc,          64'h118);
    check("sd_valid", 64'(out_a.valid),  64'd1);
    check("sd_wd",    out_a.writedata,   64'h4008);

    // Reset while a request is outstanding
    in_a = mk(64'h11C, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h6000, 64'h0);
    tick();
    tick();
    check("rreq_before", 64'(dreq_a.valid), 64'd1);
    reset = 1'b1;
    in_a  = '0;
    tick();
    check("rreq_dreq_v", 64'(dreq_a.valid), 64'd0);
    check("rreq_addr",   dreq_a.addr,       64'h0);
    check("rreq_out_v",  64'(out_a.valid),  64'd0);
    check("rreq_stall",  64'(stall_a),      64'd0);
    check("rreq_err",    64'(err_a),        64'd0);
    reset = 1'b0;
    tick();
    check("rreq_no_out", 64'(out_a.valid), 64'd0);

    // Watchdog abort after four REQ cycles
    in_b = mk(64'h200, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h5000, 64'h0);
    #1;
    check("wd_stall_idle", 64'(stall_b), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wd_stall_req%0d", i), 64'(stall_b), 64'd1);
    end
    tick();
    check("wd_last_stall", 64'(stall_b),      64'd0);
    check("wd_last_dreq",  64'(dreq_b.valid), 64'd1);
    check("wd_last_err",   64'(err_b),        64'd0);
    tick();
    in_b = '0;
    #1;
    check("wd_err",   64'(err_b),        64'd1);
    check("wd_valid", 64'(out_b.valid),  64'd1);
    check("wd_rd",    out_b.readdata,    64'h0);
    check("wd_pc",    out_b.pc,          64'h200);
    check("wd_dreq",  64'(dreq_b.valid), 64'd0);
    check("wd_stall", 64'(stall_b),      64'd0);
    tick();
    check("wd_err_pulse", 64'(err_b), 64'd0);

    // data_ok on the expiry cycle wins over the watchdog
    in_b = mk(64'h208, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h5008, 64'h0);
    for (int i = 0; i < 4; i++) tick();
    dresp_b.data_ok = 1'b1;
    dresp_b.data    = 64'h77;
    #1;
    check("wdok_stall", 64'(stall_b), 64'd0);
    tick();
    dresp_b = '0;
    in_b    = '0;
    #1;
    check("wdok_err",   64'(err_b),       64'd0);
    check("wdok_valid", 64'(out_b.valid), 64'd1);
    check("wdok_rd",    out_b.readdata,   64'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
